// File: rtl/approx_arbiter.sv
// Two-requester front end for a shared approximation core: round-robin grant,
// operand latching, result routing back to the owner and a WAIT-state watchdog.
module approx_arbiter #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic [15:0] x0_i,
    input  logic [15:0] x1_i,
    input  logic [2:0]  nIt0_i,
    input  logic [2:0]  nIt1_i,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic        valid0_o,
    output logic        valid1_o,
    output logic [16:0] y0_o,
    output logic [16:0] y1_o,
    output logic        err0_o,
    output logic        err1_o,
    output logic        busy_o,
    output logic        core_start_o,
    output logic [15:0] core_x_o,
    output logic [2:0]  core_nIt_o,
    input  logic        core_busy_i,
    input  logic        core_valid_i,
    input  logic [16:0] core_y_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic        owner, owner_next;
    logic        last, last_next;
    logic        grant_sel;
    logic        timeout;

    logic        ack0_next, ack1_next, start_next;
    logic        valid0_next, valid1_next, err0_next, err1_next;
    logic [16:0] y0_next, y1_next;
    logic [15:0] core_x_next;
    logic [2:0]  core_nIt_next;

    // With both requesting, the one not granted last wins; otherwise the lone requester.
    assign grant_sel = (req0_i && req1_i) ? ~last : req1_i;
    // Last WAIT cycle: the counter would reach TIMEOUT_CYC on this edge.
    assign timeout   = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        owner_next    = owner;
        last_next     = last;
        ack0_next     = 1'b0;
        ack1_next     = 1'b0;
        start_next    = 1'b0;
        valid0_next   = 1'b0;
        valid1_next   = 1'b0;
        err0_next     = 1'b0;
        err1_next     = 1'b0;
        y0_next       = y0_o;
        y1_next       = y1_o;
        core_x_next   = core_x_o;
        core_nIt_next = core_nIt_o;

        unique case (state)
            IDLE: begin
                if (!core_busy_i && (req0_i || req1_i)) begin
                    state_next = ISSUE;
                    owner_next = grant_sel;
                    last_next  = grant_sel;
                    start_next = 1'b1;
                    if (grant_sel) begin
                        ack1_next     = 1'b1;
                        core_x_next   = x1_i;
                        core_nIt_next = nIt1_i;
                    end else begin
                        ack0_next     = 1'b1;
                        core_x_next   = x0_i;
                        core_nIt_next = nIt0_i;
                    end
                end
            end
            ISSUE: begin
                state_next = WAIT;
                cnt_next   = '0;
            end
            WAIT: begin
                // A result arriving in the timeout cycle takes precedence over the abort.
                if (core_valid_i) begin
                    state_next = IDLE;
                    if (owner) begin
                        y1_next     = core_y_i;
                        valid1_next = 1'b1;
                    end else begin
                        y0_next     = core_y_i;
                        valid0_next = 1'b1;
                    end
                end else if (timeout) begin
                    state_next = IDLE;
                    if (owner) err1_next = 1'b1;
                    else       err0_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            owner        <= 1'b0;
            last         <= 1'b1;
            ack0_o       <= 1'b0;
            ack1_o       <= 1'b0;
            core_start_o <= 1'b0;
            valid0_o     <= 1'b0;
            valid1_o     <= 1'b0;
            err0_o       <= 1'b0;
            err1_o       <= 1'b0;
            busy_o       <= 1'b0;
            y0_o         <= '0;
            y1_o         <= '0;
            core_x_o     <= '0;
            core_nIt_o   <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            owner        <= owner_next;
            last         <= last_next;
            ack0_o       <= ack0_next;
            ack1_o       <= ack1_next;
            core_start_o <= start_next;
            valid0_o     <= valid0_next;
            valid1_o     <= valid1_next;
            err0_o       <= err0_next;
            err1_o       <= err1_next;
            busy_o       <= (state_next != IDLE);
            y0_o         <= y0_next;
            y1_o         <= y1_next;
            core_x_o     <= core_x_next;
            core_nIt_o   <= core_nIt_next;
        end
    end

endmodule
